// File: rtl/nios_system_entity_pio_bank.sv
// Avalon-MM output PIO bank: NUM_CH channels of WIDTH bits with set/clear access,
// a one-shot auto-clear countdown per channel and a registered per-channel change strobe.
module nios_system_entity_pio_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_CH*WIDTH-1:0]   out_port,
  output logic [NUM_CH-1:0]         changed
);

  typedef enum logic [1:0] {
    RegData    = 2'd0,
    RegSet     = 2'd1,
    RegClr     = 2'd2,
    RegOneshot = 2'd3
  } reg_e;

  logic [WIDTH-1:0] r_data [NUM_CH];
  logic [CNT_W-1:0] r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_changed;

  logic [WIDTH-1:0] w_data_d [NUM_CH];
  logic [CNT_W-1:0] w_cnt_d  [NUM_CH];

  logic             w_wr;
  logic [1:0]       w_ch;
  reg_e             w_reg;
  logic [WIDTH-1:0] w_wdata;
  logic [CNT_W-1:0] w_wcnt;
  logic             w_unused_wd;

  assign w_wr    = chipselect & ~write_n;
  assign w_ch    = address[3:2];
  assign w_reg   = reg_e'(address[1:0]);
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_wcnt  = writedata[CNT_W-1:0];
  // Bits above WIDTH / CNT_W are deliberately dropped.
  assign w_unused_wd = ^writedata;

  // Next state: countdown first, then a bus data write overrides any expiry clear.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_data_d[c] = r_data[c];
      w_cnt_d[c]  = r_cnt[c];
      if (w_wr && (w_ch == 2'(c)) && (w_reg == RegOneshot)) begin
        w_cnt_d[c] = w_wcnt;
      end else if (r_cnt[c] != '0) begin
        w_cnt_d[c] = r_cnt[c] - CNT_W'(1);
        if (r_cnt[c] == CNT_W'(1)) begin
          w_data_d[c] = '0;
        end
      end
      if (w_wr && (w_ch == 2'(c))) begin
        unique case (w_reg)
          RegData:    w_data_d[c] = w_wdata;
          RegSet:     w_data_d[c] = r_data[c] | w_wdata;
          RegClr:     w_data_d[c] = r_data[c] & ~w_wdata;
          RegOneshot: ;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_data[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_changed <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_data[c]    <= w_data_d[c];
        r_cnt[c]     <= w_cnt_d[c];
        r_changed[c] <= (w_data_d[c] != r_data[c]);
      end
    end
  end

  always_comb begin
    out_port = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      out_port[c*WIDTH +: WIDTH] = r_data[c];
    end
  end

  assign changed = r_changed;

  // Unimplemented channels never match and so read back as zero.
  always_comb begin
    readdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_ch == 2'(c)) begin
        unique case (w_reg)
          RegData:    readdata[WIDTH-1:0] = r_data[c];
          RegOneshot: readdata[CNT_W-1:0] = r_cnt[c];
          default:    readdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_system_entity_pio_bank.sv
// Bench for nios_system_entity_pio_bank: two instances (4x3 and 2x8) on one bus, directed
// steps then random traffic, all outputs compared against a channel-level reference model.
module tb_nios_system_entity_pio_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rdata0, rdata1;
  logic [11:0] out0;
  logic [15:0] out1;
  logic [3:0]  chg0;
  logic [1:0]  chg1;

  int checks = 0;
  int errors = 0;

  bit [63:0] m_d   [2][4];
  bit [63:0] m_c   [2][4];
  bit        m_chg [2][4];

  always #5 clk = ~clk;

  nios_system_entity_pio_bank #(.NUM_CH(4), .WIDTH(3), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata0),
    .out_port(out0), .changed(chg0)
  );

  nios_system_entity_pio_bank #(.NUM_CH(2), .WIDTH(8), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata1),
    .out_port(out1), .changed(chg1)
  );

  function automatic int nc(input int k);   return (k == 0) ? 4 : 2;  endfunction
  function automatic int wof(input int k);  return (k == 0) ? 3 : 8;  endfunction
  function automatic int cwof(input int k); return (k == 0) ? 16 : 4; endfunction
  function automatic bit [63:0] mask(input int n); return (64'd1 << n) - 64'd1; endfunction

  // One clock edge of the abstract channel model, using the bus as presented at that edge.
  task automatic model_step();
    bit        wr;
    int        ch, rg;
    bit [63:0] nd, wd;
    wr = chipselect && !write_n;
    ch = int'(address[3:2]);
    rg = int'(address[1:0]);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < nc(k); c++) begin
        if (reset) begin
          m_d[k][c] = 0; m_c[k][c] = 0; m_chg[k][c] = 0;
        end else begin
          nd = m_d[k][c];
          wd = 64'(writedata);
          if (wr && ch == c && rg == 3) begin
            m_c[k][c] = wd & mask(cwof(k));
          end else if (m_c[k][c] > 0) begin
            m_c[k][c] = m_c[k][c] - 1;
            if (m_c[k][c] == 0) nd = 0;
          end
          if (wr && ch == c) begin
            if (rg == 0) nd = wd & mask(wof(k));
            if (rg == 1) nd = m_d[k][c] | (wd & mask(wof(k)));
            if (rg == 2) nd = m_d[k][c] & ~wd & mask(wof(k));
          end
          m_chg[k][c] = (nd != m_d[k][c]);
          m_d[k][c]   = nd;
        end
      end
    end
  endtask

  function automatic bit [63:0] exp_rd(input int k, input logic [3:0] a);
    int ch;
    ch = int'(a[3:2]);
    if (ch >= nc(k)) return 0;
    if (a[1:0] == 2'd0) return m_d[k][ch];
    if (a[1:0] == 2'd3) return m_c[k][ch];
    return 0;
  endfunction

  function automatic bit [63:0] exp_out(input int k);
    bit [63:0] v;
    v = 0;
    for (int c = 0; c < nc(k); c++) v = v | (m_d[k][c] << (c * wof(k)));
    return v;
  endfunction

  function automatic bit [63:0] exp_chg(input int k);
    bit [63:0] v;
    v = 0;
    for (int c = 0; c < nc(k); c++) v[c] = m_chg[k][c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out0", 64'(out0), exp_out(0));
    chk("out1", 64'(out1), exp_out(1));
    chk("chg0", 64'(chg0), exp_chg(0));
    chk("chg1", 64'(chg1), exp_chg(1));
    chk("rd0", 64'(rdata0), exp_rd(0, address));
    chk("rd1", 64'(rdata1), exp_rd(1, address));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    chipselect = 1'b0; write_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk("rd0", 64'(rdata0), exp_rd(0, a));
    chk("rd1", 64'(rdata1), exp_rd(1, a));
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("reset_rd0", 64'(rdata0), 64'd0);
    end
    chk("reset_out0", 64'(out0), 64'd0);
    chk("reset_chg0", 64'(chg0), 64'd0);

    // DATA / SET / CLR on channel 1
    wr(4'h4, 32'h5);
    chk("ch1_data5", 64'(rdata0), 64'h5);
    chk("ch1_out5", 64'(out0[5:3]), 64'h5);
    chk("ch1_chg_a", 64'(chg0[1]), 64'd1);
    wr(4'h5, 32'h2);
    chk("ch1_set_rd0", 64'(rdata0), 64'd0);
    chk("ch1_chg_b", 64'(chg0[1]), 64'd1);
    rd(4'h4);
    chk("ch1_data7", 64'(rdata0), 64'h7);
    wr(4'h6, 32'h4);
    rd(4'h4);
    chk("ch1_data3", 64'(rdata0), 64'h3);
    idle();
    chk("ch1_chg_end", 64'(chg0[1]), 64'd0);

    // One-shot on channel 2
    wr(4'h8, 32'h7);
    wr(4'hB, 32'h3);
    chk("os_cnt3", 64'(rdata0), 64'd3);
    idle();
    chk("os_cnt2", 64'(rdata0), 64'd2);
    idle();
    chk("os_cnt1", 64'(rdata0), 64'd1);
    chk("os_data_hold", 64'(out0[8:6]), 64'h7);
    idle();
    chk("os_expired", 64'(out0[8:6]), 64'd0);
    chk("os_chg", 64'(chg0[2]), 64'd1);
    idle();
    chk("os_chg_once", 64'(chg0[2]), 64'd0);

    // Cancel by loading zero
    wr(4'h8, 32'h7);
    wr(4'hB, 32'h5);
    idle();
    wr(4'hB, 32'h0);
    repeat (6) begin
      idle();
      chk("cancel_chg", 64'(chg0[2]), 64'd0);
    end
    chk("cancel_data", 64'(out0[8:6]), 64'h7);

    // Bus write on the expiry edge
    wr(4'h0, 32'h1);
    wr(4'h3, 32'h2);
    idle();
    wr(4'h0, 32'h6);
    chk("exp_data_wins", 64'(out0[2:0]), 64'h6);
    rd(4'h3);
    chk("exp_cnt0", 64'(rdata0), 64'd0);
    wr(4'h0, 32'h2);
    wr(4'h3, 32'h2);
    idle();
    wr(4'h1, 32'h1);
    chk("exp_set_pre", 64'(out0[2:0]), 64'h3);

    // Reset mid-countdown, with a write presented during reset
    wr(4'hC, 32'h4);
    wr(4'hF, 32'h5);
    reset = 1'b1; address = 4'hC; writedata = 32'h7; chipselect = 1'b1; write_n = 1'b0;
    tick();
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("rst_data", 64'(out0[11:9]), 64'd0);
    chk("rst_chg", 64'(chg0), 64'd0);
    rd(4'hF);
    chk("rst_cnt", 64'(rdata0), 64'd0);
    repeat (7) begin
      idle();
      chk("rst_no_pulse", 64'(chg0[3]), 64'd0);
    end

    // Narrow/wide instance: unimplemented channel and width truncation
    wr(4'hC, 32'hFF);
    chk("ch3_ignored", 64'(rdata1), 64'd0);
    wr(4'h0, 32'h1AB);
    chk("trunc8", 64'(rdata1), 64'hAB);
    chk("trunc3", 64'(rdata0), 64'h3);

    // Random traffic
    repeat (600) begin
      reset      = ($urandom_range(0, 79) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 4'($urandom);
      if (address[1:0] == 2'd3 && $urandom_range(0, 7) != 0) writedata = $urandom_range(0, 12);
      else writedata = $urandom;
      tick();
      reset = 1'b0;
      if ($urandom_range(0, 3) == 0) rd(4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
